// File: rtl/dbc_port_status_regs.sv
// DbC port status / change-bit generator.
// Debounces connect, times warm reset, holds sticky W1C change bits.
module dbc_port_status_regs #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RESET_CYCLES    = 32,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       DCE,
  input  logic       link_connect,
  input  logic       link_up,
  input  logic       link_error,
  input  logic       port_reset_req,
  input  logic       w1c_csc,
  input  logic       w1c_plc,
  input  logic       w1c_prc,
  input  logic       w1c_cec,
  output logic       DCE_o,
  output logic       DCI,
  output logic       PED,
  output logic       PR,
  output logic       CSC,
  output logic       PLC,
  output logic       PRC,
  output logic       CEC,
  output logic       port_event,
  output logic [2:0] port_state
);

  typedef enum logic [2:0] {
    DISABLED     = 3'd0,
    DISCONNECTED = 3'd1,
    DEBOUNCE     = 3'd2,
    CONNECTED    = 3'd3,
    ENABLED      = 3'd4,
    RESETTING    = 3'd5,
    ERROR        = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dce_q;
  logic             dci_q, dci_d;
  logic             ped_q, ped_d;
  logic             pr_q, pr_d;
  logic             csc_q, csc_d;
  logic             plc_q, plc_d;
  logic             prc_q, prc_d;
  logic             cec_q, cec_d;
  logic             evt_q;
  logic             set_csc, set_plc, set_prc, set_cec;

  // Events are tested in priority order inside each state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    set_csc = 1'b0;
    set_plc = 1'b0;
    set_prc = 1'b0;
    set_cec = 1'b0;
    if (!DCE) begin
      state_d = DISABLED;
    end else begin
      unique case (state_q)
        DISABLED: state_d = DISCONNECTED;
        DISCONNECTED: begin
          if (link_connect) state_d = DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!link_connect) begin
            state_d = DISCONNECTED;
          end else if (cnt_q == DEB_LAST) begin
            state_d = CONNECTED;
            set_csc = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CONNECTED: begin
          if (!link_connect) begin
            state_d = DISCONNECTED;
            set_csc = 1'b1;
          end else if (link_error) begin
            state_d = ERROR;
            set_cec = 1'b1;
          end else if (port_reset_req) begin
            state_d = RESETTING;
          end else if (link_up) begin
            state_d = ENABLED;
            set_plc = 1'b1;
          end
        end
        ENABLED: begin
          if (!link_connect) begin
            state_d = DISCONNECTED;
            set_csc = 1'b1;
          end else if (link_error) begin
            state_d = ERROR;
            set_cec = 1'b1;
          end else if (port_reset_req) begin
            state_d = RESETTING;
          end else if (!link_up) begin
            state_d = CONNECTED;
            set_plc = 1'b1;
          end
        end
        RESETTING: begin
          if (!link_connect) begin
            state_d = DISCONNECTED;
            set_csc = 1'b1;
          end else if (cnt_q == RST_LAST) begin
            state_d = CONNECTED;
            set_prc = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ERROR: begin
          if (!link_connect) begin
            state_d = DISCONNECTED;
            set_csc = 1'b1;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_comb begin
    dci_d = state_d inside {CONNECTED, ENABLED, RESETTING, ERROR};
    ped_d = (state_d == ENABLED);
    pr_d  = (state_d == RESETTING);
    csc_d = DCE & (set_csc | (csc_q & ~w1c_csc));
    plc_d = DCE & (set_plc | (plc_q & ~w1c_plc));
    prc_d = DCE & (set_prc | (prc_q & ~w1c_prc));
    cec_d = DCE & (set_cec | (cec_q & ~w1c_cec));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      dce_q   <= 1'b0;
      dci_q   <= 1'b0;
      ped_q   <= 1'b0;
      pr_q    <= 1'b0;
      csc_q   <= 1'b0;
      plc_q   <= 1'b0;
      prc_q   <= 1'b0;
      cec_q   <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dce_q   <= DCE;
      dci_q   <= dci_d;
      ped_q   <= ped_d;
      pr_q    <= pr_d;
      csc_q   <= csc_d;
      plc_q   <= plc_d;
      prc_q   <= prc_d;
      cec_q   <= cec_d;
      evt_q   <= csc_d | plc_d | prc_d | cec_d;
    end
  end

  assign DCE_o      = dce_q;
  assign DCI        = dci_q;
  assign PED        = ped_q;
  assign PR         = pr_q;
  assign CSC        = csc_q;
  assign PLC        = plc_q;
  assign PRC        = prc_q;
  assign CEC        = cec_q;
  assign port_event = evt_q;
  assign port_state = state_q;

endmodule

// File: tb/tb_dbc_port_status_regs.sv
// Bench for dbc_port_status_regs: directed scenarios plus random
// stimulus, every cycle compared against a behavioural port model.
module tb_dbc_port_status_regs;

  localparam int DEB = 16;
  localparam int RST = 32;

  logic       clock;
  logic       reset;
  logic       DCE;
  logic       link_connect;
  logic       link_up;
  logic       link_error;
  logic       port_reset_req;
  logic       w1c_csc;
  logic       w1c_plc;
  logic       w1c_prc;
  logic       w1c_cec;
  logic       DCE_o;
  logic       DCI;
  logic       PED;
  logic       PR;
  logic       CSC;
  logic       PLC;
  logic       PRC;
  logic       CEC;
  logic       port_event;
  logic [2:0] port_state;

  dbc_port_status_regs #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_CYCLES(RST),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .DCE(DCE),
    .link_connect(link_connect),
    .link_up(link_up),
    .link_error(link_error),
    .port_reset_req(port_reset_req),
    .w1c_csc(w1c_csc),
    .w1c_plc(w1c_plc),
    .w1c_prc(w1c_prc),
    .w1c_cec(w1c_cec),
    .DCE_o(DCE_o),
    .DCI(DCI),
    .PED(PED),
    .PR(PR),
    .CSC(CSC),
    .PLC(PLC),
    .PRC(PRC),
    .CEC(CEC),
    .port_event(port_event),
    .port_state(port_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: port condition tracked as named flags and a tick count.
  int m_st;
  int m_ticks;
  bit m_dce, m_dci, m_ped, m_pr;
  bit m_csc, m_plc, m_prc, m_cec, m_evt;

  task automatic model_step();
    bit s_csc, s_plc, s_prc, s_cec;
    s_csc = 0; s_plc = 0; s_prc = 0; s_cec = 0;
    if (!reset) begin
      m_st = 0; m_ticks = 0; m_dce = 0;
      m_dci = 0; m_ped = 0; m_pr = 0;
      m_csc = 0; m_plc = 0; m_prc = 0; m_cec = 0; m_evt = 0;
      return;
    end
    m_dce = DCE;
    if (!DCE) begin
      m_st = 0; m_ticks = 0;
      m_dci = 0; m_ped = 0; m_pr = 0;
      m_csc = 0; m_plc = 0; m_prc = 0; m_cec = 0; m_evt = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (link_connect) begin m_st = 2; m_ticks = 0; end
    end else if (!link_connect) begin
      // Any disconnect past the idle states: CSC unless still debouncing.
      if (m_st != 2) s_csc = 1;
      m_st = 1; m_dci = 0; m_ped = 0; m_pr = 0; m_ticks = 0;
    end else if (m_st == 2) begin
      if (m_ticks + 1 == DEB) begin
        m_st = 3; m_dci = 1; s_csc = 1; m_ticks = 0;
      end else m_ticks++;
    end else if (m_st == 5) begin
      if (m_ticks + 1 == RST) begin
        m_st = 3; m_pr = 0; s_prc = 1; m_ticks = 0;
      end else m_ticks++;
    end else if (m_st == 3 || m_st == 4) begin
      if (link_error) begin
        m_st = 6; m_ped = 0; s_cec = 1;
      end else if (port_reset_req) begin
        m_st = 5; m_ped = 0; m_pr = 1; m_ticks = 0;
      end else if (m_st == 3 && link_up) begin
        m_st = 4; m_ped = 1; s_plc = 1;
      end else if (m_st == 4 && !link_up) begin
        m_st = 3; m_ped = 0; s_plc = 1;
      end
    end
    m_csc = s_csc || (m_csc && !w1c_csc);
    m_plc = s_plc || (m_plc && !w1c_plc);
    m_prc = s_prc || (m_prc && !w1c_prc);
    m_cec = s_cec || (m_cec && !w1c_cec);
    m_evt = m_csc || m_plc || m_prc || m_cec;
  endtask

  function automatic logic [11:0] dut_vec();
    return {DCE_o, DCI, PED, PR, CSC, PLC, PRC, CEC,
            port_event, port_state};
  endfunction

  function automatic logic [11:0] mdl_vec();
    logic [2:0] s;
    s = 3'(m_st);
    return {m_dce, m_dci, m_ped, m_pr, m_csc, m_plc, m_prc, m_cec,
            m_evt, s};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("outs", {20'd0, dut_vec()}, {20'd0, mdl_vec()});
  endtask

  task automatic clr_w1c();
    w1c_csc = 0; w1c_plc = 0; w1c_prc = 0; w1c_cec = 0;
  endtask

  initial begin
    reset = 0; DCE = 0; link_connect = 0; link_up = 0;
    link_error = 0; port_reset_req = 0;
    clr_w1c();
    m_st = 0; m_ticks = 0;
    repeat (2) tick();
    chk("rst_state", port_state, 0);
    chk("rst_outs", dut_vec(), 0);

    // Connect held from cycle 0
    reset = 1; DCE = 1; link_connect = 1;
    repeat (17) tick();
    chk("deb_dci_early", DCI, 0);
    tick();
    chk("deb_dci", DCI, 1);
    chk("deb_csc", CSC, 1);
    chk("deb_state", port_state, 3);
    w1c_csc = 1;
    tick();
    w1c_csc = 0;
    chk("w1c_csc", CSC, 0);
    chk("w1c_dci", DCI, 1);

    // Disconnect, then a 10-cycle glitch
    link_connect = 0;
    tick();
    chk("disc_csc", CSC, 1);
    w1c_csc = 1;
    tick();
    w1c_csc = 0;
    link_connect = 1;
    repeat (10) tick();
    link_connect = 0;
    tick();
    chk("glitch_state", port_state, 1);
    chk("glitch_dci", DCI, 0);
    chk("glitch_csc", CSC, 0);
    chk("glitch_evt", port_event, 0);

    // Connect, enable, warm reset
    link_connect = 1;
    repeat (17) tick();
    w1c_csc = 1;
    tick();
    w1c_csc = 0;
    link_up = 1;
    tick();
    chk("en_ped", PED, 1);
    chk("en_plc", PLC, 1);
    chk("en_state", port_state, 4);
    port_reset_req = 1;
    tick();
    port_reset_req = 0;
    chk("rs_ped", PED, 0);
    chk("rs_pr", PR, 1);
    repeat (RST - 1) tick();
    chk("rs_pr_last", PR, 1);
    chk("rs_prc_early", PRC, 0);
    w1c_prc = 1;
    tick();
    w1c_prc = 0;
    chk("rs_pr_done", PR, 0);
    chk("rs_prc_w1c", PRC, 1);
    chk("rs_state", port_state, 3);
    tick();
    chk("reen_state", port_state, 4);

    // Error and reset request together while enabled
    link_error = 1; port_reset_req = 1;
    tick();
    link_error = 0; port_reset_req = 0;
    chk("err_state", port_state, 6);
    chk("err_cec", CEC, 1);
    chk("err_pr", PR, 0);
    chk("err_ped", PED, 0);
    link_connect = 0;
    tick();
    chk("err_disc_state", port_state, 1);
    chk("err_disc_csc", CSC, 1);

    // DCE drop mid port reset
    w1c_csc = 1; w1c_plc = 1; w1c_prc = 1; w1c_cec = 1;
    link_up = 0;
    tick();
    clr_w1c();
    link_connect = 1;
    repeat (17) tick();
    port_reset_req = 1;
    tick();
    port_reset_req = 0;
    repeat (20) tick();
    chk("mid_rs_pr", PR, 1);
    DCE = 0;
    tick();
    chk("dce_off_outs", dut_vec(), 0);

    // Reset during debounce
    DCE = 1;
    repeat (5) tick();
    chk("pre_rst_state", port_state, 2);
    reset = 0;
    tick();
    chk("rst_deb_outs", dut_vec(), 0);
    reset = 1;

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      DCE = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) link_connect = ~link_connect;
      if ($urandom_range(0, 29) == 0) link_up = ~link_up;
      link_error = ($urandom_range(0, 59) == 0);
      port_reset_req = ($urandom_range(0, 29) == 0);
      w1c_csc = ($urandom_range(0, 7) == 0);
      w1c_plc = ($urandom_range(0, 7) == 0);
      w1c_prc = ($urandom_range(0, 7) == 0);
      w1c_cec = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
